// File: rtl/camera_readout_sequencer.sv
// Autonomous command master for the camera opcode/operand interface: capture,
// then poll bytes-available and burst-read until IMAGE_BYTES have streamed out.
module camera_readout_sequencer #(
  parameter logic [15:0] IMAGE_BYTES    = 16'd25,
  parameter int          READ_BURST     = 8,
  parameter int          SETUP_CYCLES   = 4,
  parameter int          PULSE_CYCLES   = 4,
  parameter int          SPACING_CYCLES = 16,
  parameter int          GAP_CYCLES     = 16,
  parameter int          POLL_LIMIT     = 1024
) (
  input  logic        clock_spi_in,
  input  logic        reset_spi_in,
  input  logic        start_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out,
  output logic [15:0] bytes_read_out,
  output logic [7:0]  op_code_out,
  output logic        op_code_valid_out,
  output logic [7:0]  operand_out,
  output logic        operand_valid_out,
  output logic [7:0]  operand_count_out,
  input  logic [7:0]  response_in,
  input  logic        response_valid_in,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  input  logic        data_ready_in
);

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] SPACE_LAST = 16'(SPACING_CYCLES - PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_SPACE, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {CMD_CAPTURE, CMD_POLL, CMD_READ} cmd_t;

  state_t      state, state_nxt;
  cmd_t        cmd;
  logic [15:0] cnt;
  logic [7:0]  n_ops;
  logic [7:0]  op_idx;
  logic [15:0] avail;
  logic [15:0] poll_cnt;
  logic [15:0] poll_cnt_inc;
  logic [15:0] bytes_read;
  logic        error;
  logic [7:0]  data;
  logic        data_valid;
  logic [7:0]  code;
  logic [15:0] remaining;
  logic [15:0] burst;
  logic        accept, pulse_go, sample, tx_end, fail;

  assign poll_cnt_inc = poll_cnt + 16'd1;

  // Burst length is the smallest of what the camera has, the burst cap and what is still owed.
  always_comb begin
    remaining = IMAGE_BYTES - bytes_read;
    burst     = avail;
    if (burst > 16'(READ_BURST)) burst = 16'(READ_BURST);
    if (burst > remaining)       burst = remaining;
  end

  always_comb begin
    case (cmd)
      CMD_CAPTURE: code = 8'h20;
      CMD_POLL:    code = 8'h21;
      default:     code = 8'h22;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pulse_go  = 1'b0;
    sample    = 1'b0;
    tx_end    = 1'b0;
    fail      = 1'b0;
    case (state)
      S_IDLE: if (start_in) begin
        state_nxt = S_SETUP;
        accept    = 1'b1;
      end
      S_SETUP: if (cnt == SETUP_LAST) begin
        if (n_ops == 8'd0) tx_end = 1'b1;
        else begin
          state_nxt = S_PULSE;
          pulse_go  = 1'b1;
        end
      end
      S_PULSE: if (cnt == PULSE_LAST) begin
        sample = 1'b1;
        if (!response_valid_in) begin
          fail      = 1'b1;
          state_nxt = S_IDLE;
        end else state_nxt = S_SPACE;
      end
      // A pending output byte stretches the spacing so it is never overwritten.
      S_SPACE: if (cnt == SPACE_LAST && !data_valid) begin
        if (op_idx == n_ops) tx_end = 1'b1;
        else begin
          state_nxt = S_PULSE;
          pulse_go  = 1'b1;
        end
      end
      S_GAP:   if (cnt == GAP_LAST) state_nxt = S_SETUP;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (tx_end) begin
      case (cmd)
        CMD_POLL: begin
          if (avail == 16'd0 && poll_cnt_inc == 16'(POLL_LIMIT)) begin
            fail      = 1'b1;
            state_nxt = S_IDLE;
          end else state_nxt = S_GAP;
        end
        CMD_READ: state_nxt = (bytes_read == IMAGE_BYTES) ? S_DONE : S_GAP;
        default:  state_nxt = S_GAP;
      endcase
    end
  end

  always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
    if (reset_spi_in) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state_nxt == S_IDLE) cnt <= '0;
      else if (!(state == S_SPACE && cnt == SPACE_LAST)) cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
    if (reset_spi_in) begin
      cmd        <= CMD_CAPTURE;
      n_ops      <= '0;
      op_idx     <= '0;
      avail      <= '0;
      poll_cnt   <= '0;
      bytes_read <= '0;
      error      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      if (data_valid && data_ready_in) begin
        data_valid <= 1'b0;
        bytes_read <= bytes_read + 16'd1;
      end
      if (sample && response_valid_in) begin
        if (cmd == CMD_POLL) begin
          if (op_idx == 8'd1) avail[15:8] <= response_in;
          else                avail[7:0]  <= response_in;
        end
        if (cmd == CMD_READ) begin
          data       <= response_in;
          data_valid <= 1'b1;
        end
      end
      if (pulse_go) op_idx <= op_idx + 8'd1;
      if (accept) begin
        cmd        <= CMD_CAPTURE;
        n_ops      <= 8'd0;
        error      <= 1'b0;
        bytes_read <= '0;
        poll_cnt   <= '0;
      end
      if (tx_end) begin
        case (cmd)
          CMD_POLL: begin
            if (avail == 16'd0) begin
              poll_cnt <= poll_cnt_inc;
              cmd      <= CMD_POLL;
              n_ops    <= 8'd2;
            end else begin
              poll_cnt <= '0;
              cmd      <= CMD_READ;
              n_ops    <= burst[7:0];
            end
          end
          default: begin
            cmd   <= CMD_POLL;
            n_ops <= 8'd2;
          end
        endcase
      end
      if (tx_end || fail) op_idx <= '0;
      if (fail) error <= 1'b1;
    end
  end

  assign op_code_valid_out = (state == S_SETUP) || (state == S_PULSE) || (state == S_SPACE);
  assign op_code_out       = op_code_valid_out ? code : 8'h00;
  assign operand_valid_out = (state == S_PULSE);
  assign operand_count_out = op_idx;
  assign operand_out       = 8'h00;
  assign busy_out          = (state != S_IDLE) && (state != S_DONE);
  assign done_out          = (state == S_DONE);
  assign error_out         = error;
  assign bytes_read_out    = bytes_read;
  assign data_out          = data;
  assign data_valid_out    = data_valid;

endmodule

// File: doc/camera_readout_sequencer.md
Name: camera_readout_sequencer

Overview:
- Autonomous master for the camera block's opcode/operand command interface.
- On a start pulse it issues the capture command (0x20), then repeats two steps until IMAGE_BYTES bytes have been delivered:
  - polls bytes-available (0x21);
  - burst-reads (0x22) into a valid/ready byte stream.
- Sits between the camera block and an on-FPGA consumer (compressor/FIFO), replacing the external SPI host for self-contained captures.

Parameters:
- IMAGE_BYTES, 16'd25, total bytes expected per capture (1..65535).
- READ_BURST, 8, max data operands per 0x22 transaction (1..255).
- SETUP_CYCLES, 4, cycles op_code_valid_out is high before the first operand pulse.
- PULSE_CYCLES, 4, width of each operand_valid_out pulse.
- SPACING_CYCLES, 16, cycles from one operand pulse rising edge to the next (must exceed PULSE_CYCLES).
- GAP_CYCLES, 16, idle cycles with op_code_valid_out low between transactions.
- POLL_LIMIT, 1024, consecutive zero-result polls before timeout.

Ports:
- clock_spi_in  input  1  single system clock.
- reset_spi_in  input  1  asynchronous, active-high reset.
- start_in  input  1  one-cycle start request; ignored unless idle.
- busy_out  output  1  high from accepted start until done/error.
- done_out  output  1  one-cycle pulse on successful completion.
- error_out  output  1  sticky poll timeout or missing response; cleared by next accepted start.
- bytes_read_out  output  16  bytes delivered this capture.
- op_code_out  output  8  command to camera.
- op_code_valid_out  output  1  high for the whole transaction.
- operand_out  output  8  always 8'h00.
- operand_valid_out  output  1  operand strobe.
- operand_count_out  output  8  1-based operand index, 0 outside transactions.
- response_in  input  8  camera response byte.
- response_valid_in  input  1  camera response valid.
- data_out  output  8  image byte.
- data_valid_out  output  1  byte valid; held until accepted.
- data_ready_in  input  1  consumer ready.

Behaviour:
- Reset: async, immediate, from any state. All outputs 0, state IDLE. Any in-flight transaction is abandoned and the output byte is dropped.
- States: IDLE -> CAPTURE -> GAP -> POLL -> GAP -> (READ -> GAP -> POLL ...) -> DONE -> IDLE.
- Transaction framing:
  - Assert op_code_out and op_code_valid_out; wait SETUP_CYCLES.
  - Issue operand pulses at SPACING_CYCLES pitch. operand_count_out increments on each pulse rising edge and holds between pulses.
  - After the last pulse falls, wait SPACING_CYCLES - PULSE_CYCLES.
  - Drop op_code_valid_out, zero operand_count_out, then spend GAP_CYCLES in GAP.
- Response sampling: response_in is sampled on the last cycle of each operand pulse. If response_valid_in is low on that cycle, set error_out, pulse nothing else, and go to IDLE.
- CAPTURE: opcode 0x20, zero operands. Sets bytes_read_out=0 and poll counter=0.
- POLL:
  - Opcode 0x21, two operands. Responses form avail[15:8] then avail[7:0].
  - avail==0: increment poll counter; at POLL_LIMIT set error_out and go to IDLE; otherwise GAP then POLL again.
  - avail!=0: clear poll counter. Burst length n = min(avail, READ_BURST, IMAGE_BYTES - bytes_read_out), computed at 16 bits.
- READ:
  - Opcode 0x22, n operands. Each sampled response loads data_out and sets data_valid_out.
  - A byte transfers on data_valid_out & data_ready_in; bytes_read_out increments that cycle.
  - Backpressure: the next operand pulse is not started while data_valid_out is high. Pulse spacing stretches; no byte is ever lost or overwritten.
  - After n operands and the final byte has transferred: go to DONE if bytes_read_out==IMAGE_BYTES, else GAP then POLL.
- DONE: done_out high one cycle, busy_out falls the same cycle, return to IDLE.
- start_in while busy: ignored.
- start_in in the same cycle done_out pulses: ignored.
- start_in and reset together: reset wins.
- Width rules: bytes_read_out never exceeds IMAGE_BYTES. operand_count_out wraps never (n<=255).

Test Plan:
- Reset values: assert reset_spi_in mid-READ -> all outputs 0 immediately; after release, start_in accepted normally.
- Nominal, IMAGE_BYTES=25, READ_BURST=10, camera model yielding 25 bytes -> command sequence 0x20, then (0x21, 0x22×10), (0x21, 0x22×10), (0x21, 0x22×5); 25 ordered bytes on data_out; done_out one pulse; bytes_read_out=25.
- Framing: check SETUP_CYCLES=4 and PULSE_CYCLES=4; operand_count_out 1,2 during poll then 0; op_code_valid_out low exactly 16 cycles between transactions.
- Backpressure: data_ready_in low 50 cycles at byte 3 -> operand pulse 4 delayed until byte 3 accepted; data_out stable while waiting; no byte loss.
- Poll timeout: POLL_LIMIT=4, camera avail always 0 -> four 0x21 polls then error_out=1, busy_out=0, no done_out; next start clears error_out.
- Missing response: response_valid_in held low during a 0x22 operand -> error_out=1, idle, op_code_valid_out=0.
